// File: rtl/mdu_iter_if.sv
// Execute-stage <-> multiply/divide unit handshake bundle.
// Execute drives operands and funct3; the unit returns ok and the result.
interface mdu_iter_if;
  logic        valid;
  logic [2:0]  op;
  logic        word;
  logic [63:0] a;
  logic [63:0] b;
  logic        flush;
  logic        ok;
  logic [63:0] result;

  modport master (
    output valid, op, word, a, b, flush,
    input  ok, result
  );

  modport slave (
    input  valid, op, word, a, b, flush,
    output ok, result
  );
endinterface

// File: rtl/mdu_iter.sv
// Multi-cycle RV64M multiply/divide unit: MUL* via a multicycle product, DIV/REM via restoring radix-2.
// Optional macro MDU_EARLY_OUT_EN: divide-by-zero and signed overflow complete in cycle 1.
module mdu_iter #(
  parameter int MUL_CYCLES = 3,
  parameter int XLEN       = 64
) (
  input logic       clk,
  input logic       reset,
  mdu_iter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam logic [6:0]      MUL_LAST = 7'(MUL_CYCLES - 2);
  localparam logic [XLEN-1:0] MIN_D    = 64'h8000_0000_0000_0000;
  localparam logic [XLEN-1:0] MIN_W    = 64'hFFFF_FFFF_8000_0000;

  state_t          state_q, state_d;
  logic [6:0]      cnt_q, cnt_d;
  logic            word_q, word_d;
  logic            sel_hi_q, sel_hi_d;
  logic            sel_rem_q, sel_rem_d;
  logic [XLEN:0]   a_q, a_d;
  logic [XLEN:0]   b_q, b_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic            div0_q, div0_d;
  logic            ovf_q, ovf_d;
  logic [XLEN-1:0] result_q, result_d;

  // Final divide result: special cases override the sign-corrected magnitudes.
  function automatic logic [63:0] div_result(
    input logic        sel_rem,
    input logic        word,
    input logic        div0,
    input logic        ovf,
    input logic        negq,
    input logic        negr,
    input logic [63:0] dvd,
    input logic [63:0] quo,
    input logic [63:0] rem
  );
    logic [63:0] q;
    logic [63:0] r;
    logic [63:0] res;
    q = negq ? -quo : quo;
    r = negr ? -rem : rem;
    if (div0) begin
      q = '1;
      r = dvd;
    end else if (ovf) begin
      q = dvd;
      r = '0;
    end
    res = sel_rem ? r : q;
    if (word) begin
      res = {{32{res[31]}}, res[31:0]};
    end
    return res;
  endfunction

  // Operand decode straight from the bus, used only at latch time.
  logic            a_signed, b_signed;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_x, b_x;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div0_c, ovf_c;

  always_comb begin
    if (bus.op[2]) begin
      a_signed = !bus.op[0];
      b_signed = !bus.op[0];
    end else begin
      a_signed = (bus.op[1:0] != 2'b11);
      b_signed = !bus.op[1];
    end
    a_x    = bus.word ? {{32{a_signed & bus.a[31]}}, bus.a[31:0]} : bus.a;
    b_x    = bus.word ? {{32{b_signed & bus.b[31]}}, bus.b[31:0]} : bus.b;
    a_neg  = a_signed & a_x[XLEN-1];
    b_neg  = b_signed & b_x[XLEN-1];
    a_mag  = a_neg ? -a_x : a_x;
    b_mag  = b_neg ? -b_x : b_x;
    div0_c = (b_x == '0);
    ovf_c  = a_signed && (b_x == '1) && (a_x == (bus.word ? MIN_W : MIN_D));
  end

  // The operands are stable from cycle 0, so the product path has MUL_CYCLES-1 cycles to settle.
  logic [127:0]    a_wide, b_wide, prod;
  logic [XLEN-1:0] mul_res;

  always_comb begin
    a_wide  = {{63{a_q[XLEN]}}, a_q};
    b_wide  = {{63{b_q[XLEN]}}, b_q};
    prod    = a_wide * b_wide;
    mul_res = sel_hi_q ? prod[127:64] : prod[63:0];
    if (word_q) begin
      mul_res = {{32{mul_res[31]}}, mul_res[31:0]};
    end
  end

  // One restoring step: shift the next dividend bit into the partial remainder.
  logic [XLEN:0]   shifted;
  logic            ge;
  logic [XLEN-1:0] diff;
  logic [XLEN-1:0] rem_step, quo_step;

  always_comb begin
    shifted  = {rem_q, quo_q[XLEN-1]};
    ge       = (shifted >= {1'b0, dvs_q});
    diff     = shifted[XLEN-1:0] - dvs_q;
    rem_step = ge ? diff : shifted[XLEN-1:0];
    quo_step = {quo_q[XLEN-2:0], ge};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    sel_hi_d  = sel_hi_q;
    sel_rem_d = sel_rem_q;
    a_d       = a_q;
    b_d       = b_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    div0_d    = div0_q;
    ovf_d     = ovf_q;
    result_d  = result_q;

    unique case (state_q)
      IDLE: begin
        if (bus.valid && !bus.flush) begin
          cnt_d     = '0;
          word_d    = bus.word;
          sel_hi_d  = (bus.op[1:0] != 2'b00);
          sel_rem_d = bus.op[1];
          a_d       = {a_neg, a_x};
          b_d       = {b_neg, b_x};
          dvd_d     = a_x;
          dvs_d     = b_mag;
          // Word dividends sit in the top half so 32 shifts leave the quotient in [31:0].
          quo_d     = bus.word ? {a_mag[31:0], 32'b0} : a_mag;
          rem_d     = '0;
          negq_d    = a_neg ^ b_neg;
          negr_d    = a_neg;
          div0_d    = div0_c;
          ovf_d     = ovf_c;
          state_d   = bus.op[2] ? DIV : MUL;
`ifdef MDU_EARLY_OUT_EN
          if (bus.op[2] && (div0_c || ovf_c)) begin
            state_d  = DONE;
            result_d = div_result(bus.op[1], bus.word, div0_c, ovf_c,
                                  1'b0, 1'b0, a_x, '0, '0);
          end
`endif
        end
      end
      MUL: begin
        if (cnt_q == MUL_LAST) begin
          state_d  = DONE;
          result_d = mul_res;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      DIV: begin
        quo_d = quo_step;
        rem_d = rem_step;
        if (cnt_q == (word_q ? 7'd31 : 7'd63)) begin
          state_d  = DONE;
          result_d = div_result(sel_rem_q, word_q, div0_q, ovf_q, negq_q, negr_q,
                                dvd_q, quo_step, rem_step);
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (bus.flush) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      word_q    <= 1'b0;
      sel_hi_q  <= 1'b0;
      sel_rem_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      sel_hi_q  <= sel_hi_d;
      sel_rem_q <= sel_rem_d;
      a_q       <= a_d;
      b_q       <= b_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      div0_q    <= div0_d;
      ovf_q     <= ovf_d;
      result_q  <= result_d;
    end
  end

  // Flush wins over completion, so ok drops in the same cycle flush is raised.
  assign bus.ok     = (state_q == DONE) && !bus.flush;
  assign bus.result = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter (MUL_CYCLES=3) with hand-computed results.
// Completion cycle is counted from the cycle valid is first seen in IDLE.
module tb_mdu_iter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_iter_if bus ();

  mdu_iter #(.MUL_CYCLES(3), .XLEN(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef MDU_EARLY_OUT_EN
  localparam int SP64 = 1;
  localparam int SP32 = 1;
`else
  localparam int SP64 = 65;
  localparam int SP32 = 33;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called one time unit after a rising edge; returns one time unit after the cycle following ok.
  task automatic run_op(input string tag, input logic [2:0] op, input logic word,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int exp_cyc);
    int cyc;
    bus.valid = 1'b1;
    bus.op    = op;
    bus.word  = word;
    bus.a     = a;
    bus.b     = b;
    cyc       = 0;
    while (bus.ok !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, " ok cycle"}, 64'(cyc), 64'(exp_cyc));
    check({tag, " result"}, bus.result, exp);
    $display("txn %s a=%h b=%h result=%h ok_cycle=%0d", tag, a, b, bus.result, cyc);
    bus.valid = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " ok drop"}, {63'b0, bus.ok}, 64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    bus.valid = 1'b0;
    bus.flush = 1'b0;
    bus.op    = 3'b000;
    bus.word  = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #12;
    check("reset ok", {63'b0, bus.ok}, 64'd0);
    check("reset result", bus.result, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_op("MUL 7*-3", 3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 3);
    run_op("MULHU max*max", 3'b011, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 3);
    run_op("MULH -1*-1", 3'b001, 1'b0, '1, '1, 64'd0, 3);
    run_op("MULHSU -1*2", 3'b010, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 3);
    run_op("MULW 7fffffff*2", 3'b000, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 3);
    run_op("DIV -20/6", 3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_op("REM -20%6", 3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_op("DIVUW", 3'b101, 1'b1, 64'h0000_0001_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33);
    run_op("REMW -7%2", 3'b110, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    run_op("DIVU 5/0", 3'b101, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, SP64);
    run_op("REM ovf", 3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, SP64);
    run_op("REMUW x/0", 3'b111, 1'b1, 64'h0000_0000_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, SP32);
    run_op("DIVW ovf", 3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, SP32);

    // Flush a divide in cycle 10, then a fresh MUL starts in cycle 12.
    bus.valid = 1'b1;
    bus.op    = 3'b100;
    bus.word  = 1'b0;
    bus.a     = 64'd100;
    bus.b     = 64'd7;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    bus.flush = 1'b1;
    #1;
    check("flush ok forced low", {63'b0, bus.ok}, 64'd0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.valid = 1'b0;
    check("after flush ok", {63'b0, bus.ok}, 64'd0);
    @(posedge clk);
    #1;
    run_op("MULHU after flush", 3'b011, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 3);

    // Asynchronous reset in the middle of cycle 20 of a divide.
    bus.valid = 1'b1;
    bus.op    = 3'b100;
    bus.word  = 1'b0;
    bus.a     = 64'hFFFF_FFFF_FFFF_FFEC;
    bus.b     = 64'd6;
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    #2;
    reset = 1'b1;
    #1;
    check("async reset ok", {63'b0, bus.ok}, 64'd0);
    check("async reset result", bus.result, 64'd0);
    bus.valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_op("MUL b2b", 3'b000, 1'b0, 64'h1234, 64'h10, 64'h12340, 3);
    run_op("DIVU b2b", 3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 65);
    run_op("REMU b2b", 3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 65);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
